// File: rtl/conv_frame_packer.sv
`default_nettype none
// ============================================================================
// Module      : conv_frame_packer
// Description : Packs rate-1/2 or rate-1/3 convolutional-encoder symbols
//               MSB-first into FRAME_W-bit code frames, with a one-frame
//               output holding register and valid/ready handshakes on both
//               sides. Optional macro PACKER_PARITY_EN adds o_frame_parity
//               (even parity over o_frame).
// Revision    : 1.0 - initial release
// ============================================================================
module conv_frame_packer #(
    parameter int MAX_CODE_RATE = 3,
    parameter int FRAME_W       = 24,
    parameter int CNT_W         = 5
) (
    input  logic                     sys_clk,
    input  logic                     rst,
    input  logic                     i_mode_sel,
    input  logic [MAX_CODE_RATE-1:0] i_sym,
    input  logic                     i_sym_valid,
    output logic                     o_sym_ready,
    input  logic                     i_flush,
    output logic [FRAME_W-1:0]       o_frame,
    output logic [CNT_W-1:0]         o_frame_len,
    output logic                     o_frame_valid,
    input  logic                     i_frame_ready,
    output logic                     o_busy
`ifdef PACKER_PARITY_EN
    ,
    output logic                     o_frame_parity
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]         c_frame_w   = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0]         c_step2     = CNT_W'(2);
    localparam logic [CNT_W-1:0]         c_step3     = CNT_W'(3);
    localparam logic [MAX_CODE_RATE-1:0] c_mask2     = MAX_CODE_RATE'(2'b11);
    localparam logic [MAX_CODE_RATE-1:0] c_mask3     = MAX_CODE_RATE'(3'b111);

    // Fill-side state
    state_t               r_state;
    logic [FRAME_W-1:0]   r_buf;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_rate3;

    // Output holding register
    logic [FRAME_W-1:0]   r_frame;
    logic [CNT_W-1:0]     r_frame_len;
    logic                 r_frame_valid;

    // Next-state values
    state_t               w_state_nxt;
    logic [FRAME_W-1:0]   w_buf_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic                 w_rate3_nxt;
    logic [FRAME_W-1:0]   w_frame_nxt;
    logic [CNT_W-1:0]     w_len_nxt;
    logic                 w_valid_nxt;

    // Datapath helpers
    logic                     w_out_free;
    logic                     w_accept;
    logic                     w_rate3;
    logic [CNT_W-1:0]         w_step;
    logic [CNT_W-1:0]         w_shift;
    logic [CNT_W-1:0]         w_cnt_add;
    logic [MAX_CODE_RATE-1:0] w_sym_masked;
    logic [FRAME_W-1:0]       w_sym_ext;
    logic [FRAME_W-1:0]       w_ins_buf;
    logic [FRAME_W-1:0]       w_fill_buf;
    logic [CNT_W-1:0]         w_fill_cnt;
    logic                     w_close;

    // Output register can take a frame when empty or being drained this cycle
    assign w_out_free   = !r_frame_valid || i_frame_ready;
    assign o_sym_ready  = (r_state != ST_FULL);
    assign w_accept     = i_sym_valid && o_sym_ready;

    // The rate is sampled from i_mode_sel only on the first symbol of a frame
    assign w_rate3      = (r_state == ST_IDLE) ? i_mode_sel : r_rate3;
    assign w_step       = w_rate3 ? c_step3 : c_step2;
    assign w_sym_masked = i_sym & (w_rate3 ? c_mask3 : c_mask2);
    assign w_sym_ext    = FRAME_W'(w_sym_masked);

    // Symbol lands just below the bits already filled (MSB-first packing)
    assign w_shift      = c_frame_w - r_cnt - w_step;
    assign w_ins_buf    = r_buf | (w_sym_ext << w_shift);
    assign w_cnt_add    = r_cnt + w_step;

    // Buffer contents after this cycle's symbol, if any (symbol before flush)
    assign w_fill_buf   = w_accept ? w_ins_buf : r_buf;
    assign w_fill_cnt   = w_accept ? w_cnt_add : r_cnt;

    // Frame closes on reaching full width or on a flush of a non-empty buffer
    assign w_close      = (r_state != ST_FULL) &&
                          ((w_accept && (w_cnt_add == c_frame_w)) ||
                           (i_flush && (w_fill_cnt != '0)));

    // Next-state, fill buffer and output-register load decisions
    always_comb begin
        w_state_nxt = r_state;
        w_buf_nxt   = r_buf;
        w_cnt_nxt   = r_cnt;
        w_rate3_nxt = r_rate3;
        w_frame_nxt = r_frame;
        w_len_nxt   = r_frame_len;
        w_valid_nxt = r_frame_valid && !i_frame_ready;

        case (r_state)
            ST_FULL: begin
                if (w_out_free) begin
                    w_frame_nxt = r_buf;
                    w_len_nxt   = r_cnt;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = ST_IDLE;
                    w_buf_nxt   = '0;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                if (w_accept && (r_state == ST_IDLE)) begin
                    w_rate3_nxt = i_mode_sel;
                end
                if (w_close) begin
                    if (w_out_free) begin
                        w_frame_nxt = w_fill_buf;
                        w_len_nxt   = w_fill_cnt;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = ST_IDLE;
                        w_buf_nxt   = '0;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = ST_FULL;
                        w_buf_nxt   = w_fill_buf;
                        w_cnt_nxt   = w_fill_cnt;
                    end
                end else if (w_accept) begin
                    w_state_nxt = ST_FILL;
                    w_buf_nxt   = w_ins_buf;
                    w_cnt_nxt   = w_cnt_add;
                end
            end
        endcase
    end

    // State, fill buffer and output holding register
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_buf         <= '0;
            r_cnt         <= '0;
            r_rate3       <= 1'b0;
            r_frame       <= '0;
            r_frame_len   <= '0;
            r_frame_valid <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_buf         <= w_buf_nxt;
            r_cnt         <= w_cnt_nxt;
            r_rate3       <= w_rate3_nxt;
            r_frame       <= w_frame_nxt;
            r_frame_len   <= w_len_nxt;
            r_frame_valid <= w_valid_nxt;
        end
    end

    assign o_frame       = r_frame;
    assign o_frame_len   = r_frame_len;
    assign o_frame_valid = r_frame_valid;
    assign o_busy        = (r_state != ST_IDLE) || r_frame_valid;

`ifdef PACKER_PARITY_EN
    logic r_parity;

    // Parity tracks the output register; it follows the same hold behaviour
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            r_parity <= 1'b0;
        end else begin
            r_parity <= ^w_frame_nxt;
        end
    end

    assign o_frame_parity = r_parity;
`endif

endmodule
`default_nettype wire
